rsg_sequencer: RTL and testbench
================================

Name: rsg_sequencer

Overview:
- Generates the one-hot ready/set/going phase vector that the phase decoder consumes.
- A start request launches a timed sequence IDLE -> READY -> SET -> GOING -> IDLE, with a programmable dwell time in each phase.
- Supports pause (hold) and abort (stop).
- Sits in the control path upstream of the phase decoder; its current_state output connects directly to the decoder's current_state input.

Parameters:
- READY_CYCLES, 4: dwell cycles in READY; must be >= 1.
- SET_CYCLES, 4: dwell cycles in SET; must be >= 1.
- GOING_CYCLES, 8: dwell cycles in GOING; 0 means remain in GOING until stop.
- CNT_W, 8: dwell counter width; every *_CYCLES value must be < 2**CNT_W.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  launch request; sampled only in IDLE.
- stop  input  1  abort request; any active phase returns to IDLE.
- hold  input  1  freezes phase and dwell counter while high.
- current_state  output  3  one-hot phase: bit0 READY, bit1 SET, bit2 GOING, 000 IDLE.
- busy  output  1  high whenever current_state != 000.
- done  output  1  one-cycle pulse on natural completion of GOING.
- aborted  output  1  one-cycle pulse when stop terminates an active phase.

Behaviour:
- Reset: asynchronous assert on rst_n low. Resets current_state=000, busy=0, done=0, aborted=0, counter=0. Release is synchronous to clk. Reset mid-sequence drops to IDLE immediately and pulses neither done nor aborted.
- Registered outputs: all outputs come from registers; none is combinational from inputs.
- Legal encodings: current_state is always one of 000/001/010/100, never multi-hot.
- IDLE, start=1, stop=0: next cycle enters READY and loads counter = READY_CYCLES-1.
- Dwell countdown: in an active phase with hold=0 and stop=0, the counter decrements each cycle. Counter==0 advances the phase at the next edge:
  - READY -> SET, loading SET_CYCLES-1.
  - SET -> GOING, loading GOING_CYCLES-1.
  - GOING -> IDLE, with done=1 in the cycle IDLE is first visible.
- Exact dwell: READY occupies exactly READY_CYCLES cycles (same for SET and GOING when nonzero). Total start-to-done latency is 1 + READY_CYCLES + SET_CYCLES + GOING_CYCLES cycles.
- GOING_CYCLES=0: no countdown in GOING; it persists until stop.
- stop in any active phase: IDLE at the next edge, aborted=1 for one cycle, done=0. stop has priority over hold and over a same-cycle natural transition. stop in IDLE has no effect and no pulse.
- hold=1 in an active phase (stop=0): phase and counter are frozen; done and aborted stay 0. hold in IDLE does not block start.
- start and stop in the same cycle in IDLE: stop wins; remain in IDLE.
- start while busy: ignored, with no queuing or restart.
- start held high continuously: a new sequence begins the cycle after done, i.e. IDLE lasts exactly one cycle.
- Pulse exclusivity: done and aborted are never high together.
- Illegal parameters: out-of-range parameters are rejected by elaboration-time assertions.

Decomposition:
- Shared package rsg_pkg:
  - Phase constants PH_IDLE=3'b000, PH_READY=3'b001, PH_SET=3'b010, PH_GOING=3'b100.
  - Phase typedef for the 3-bit vector.
  - Bit-index constants for READY, SET and GOING.
- Sub-module dwell_counter (CNT_W):
  - Inputs: load, load_val, en.
  - Output: zero flag.
- Top level: the phase register and next-phase logic plus the output pulse registers.

Test Plan:
- Defaults 4/4/8; pulse start for 1 cycle at t0 -> READY cycles t1..t4, SET t5..t8, GOING t9..t16, IDLE with done=1 at t17, busy low at t17.
- Stop while in SET (2nd SET cycle) -> next cycle current_state=000 and aborted=1 for exactly 1 cycle; done never asserts.
- hold=1 for 5 cycles in the 2nd READY cycle -> READY lasts 4+5=9 cycles total; the remaining sequence timing is unchanged.
- GOING_CYCLES=0, start -> GOING persists for 100 cycles with no done; stop -> IDLE with aborted pulse.
- Same-cycle start+stop in IDLE -> remains 000; start while busy mid-GOING -> no restart, done still at its original cycle.
- rst_n low mid-GOING (async, between edges) -> current_state=000 immediately with no pulse; continuous-run check: start held high -> exactly 1 IDLE cycle between sequences.
- Every cycle, all scenarios: assert one-hot/zero invariant on current_state and done/aborted mutual exclusion.

Source files
------------

// File: rtl/rsg_pkg.sv
// Shared phase encoding for the ready/set/going sequencer and its downstream
// phase decoder.
package rsg_pkg;

  localparam int PH_READY_BIT = 0;
  localparam int PH_SET_BIT   = 1;
  localparam int PH_GOING_BIT = 2;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'b000,
    PH_READY = 3'b001,
    PH_SET   = 3'b010,
    PH_GOING = 3'b100
  } phase_t;

endpackage : rsg_pkg

// File: rtl/rsg_dwell_counter.sv
// Loadable down-counter that measures phase dwell time; saturates at zero.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule : dwell_counter

// File: rtl/rsg_sequencer.sv
// Timed IDLE -> READY -> SET -> GOING -> IDLE phase sequencer with hold/stop
// and registered one-cycle done/aborted pulses.
module rsg_sequencer
  import rsg_pkg::*;
#(
  parameter int READY_CYCLES = 4,
  parameter int SET_CYCLES   = 4,
  parameter int GOING_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       hold,
  output logic [2:0] current_state,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  if (READY_CYCLES < 1 || READY_CYCLES >= 2**CNT_W) begin : g_bad_ready
    $error("READY_CYCLES out of range");
  end
  if (SET_CYCLES < 1 || SET_CYCLES >= 2**CNT_W) begin : g_bad_set
    $error("SET_CYCLES out of range");
  end
  if (GOING_CYCLES < 0 || GOING_CYCLES >= 2**CNT_W) begin : g_bad_going
    $error("GOING_CYCLES out of range");
  end

  // Counter reload values: the phase advances on the edge after the counter reads zero.
  localparam logic [CNT_W-1:0] READY_LD = CNT_W'(READY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LD   = CNT_W'(SET_CYCLES - 1);
  localparam logic [CNT_W-1:0] GOING_LD = (GOING_CYCLES == 0) ? '0 : CNT_W'(GOING_CYCLES - 1);

  phase_t           phase_d, phase_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             aborted_d, aborted_q;
  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_comb begin
    phase_d    = phase_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    cnt_en     = 1'b0;

    if (phase_q == PH_IDLE) begin
      if (start && !stop) begin
        phase_d    = PH_READY;
        cnt_load   = 1'b1;
        cnt_ld_val = READY_LD;
      end
    end else if (stop) begin
      phase_d   = PH_IDLE;
      aborted_d = 1'b1;
    end else if (!hold) begin
      case (phase_q)
        PH_READY: begin
          if (cnt_zero) begin
            phase_d    = PH_SET;
            cnt_load   = 1'b1;
            cnt_ld_val = SET_LD;
          end else begin
            cnt_en = 1'b1;
          end
        end
        PH_SET: begin
          if (cnt_zero) begin
            phase_d    = PH_GOING;
            cnt_load   = 1'b1;
            cnt_ld_val = GOING_LD;
          end else begin
            cnt_en = 1'b1;
          end
        end
        PH_GOING: begin
          // A zero GOING dwell means run until stopped.
          if (GOING_CYCLES != 0) begin
            if (cnt_zero) begin
              phase_d = PH_IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        default: phase_d = PH_IDLE;
      endcase
    end

    busy_d = (phase_d != PH_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= PH_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign current_state = phase_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule : rsg_sequencer

// File: tb/tb_rsg_sequencer.sv
// Self-checking bench: a default-parameter DUT and a GOING_CYCLES=0 DUT share
// stimulus and are compared every cycle against an elapsed-time model.
module tb_rsg_sequencer;

  localparam int R = 4;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, stop = 1'b0, hold = 1'b0;
  logic [2:0] cs8, cs0;
  logic       busy8, busy0, done8, done0, ab8, ab0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rsg_sequencer #(.READY_CYCLES(4), .SET_CYCLES(4), .GOING_CYCLES(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .current_state(cs8), .busy(busy8), .done(done8), .aborted(ab8)
  );

  rsg_sequencer #(.READY_CYCLES(4), .SET_CYCLES(4), .GOING_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .hold(hold),
    .current_state(cs0), .busy(busy0), .done(done0), .aborted(ab0)
  );

  // Model: t counts un-held cycles since the sequence began; phase follows from t.
  typedef struct {
    bit active;
    int t;
    bit done;
    bit aborted;
  } mdl_t;

  mdl_t m8, m0;

  function automatic mdl_t step(mdl_t m, bit st, bit sp, bit hd, int g);
    mdl_t n = m;
    n.done    = 1'b0;
    n.aborted = 1'b0;
    if (!m.active) begin
      if (st && !sp) begin
        n.active = 1'b1;
        n.t      = 0;
      end
    end else if (sp) begin
      n.active  = 1'b0;
      n.aborted = 1'b1;
    end else if (!hd) begin
      n.t = m.t + 1;
      if (g != 0 && n.t == R + S + g) begin
        n.active = 1'b0;
        n.done   = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic int phase_of(mdl_t m);
    if (!m.active)    return 0;
    if (m.t < R)      return 1;
    if (m.t < R + S)  return 2;
    return 4;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8 <= '{1'b0, 0, 1'b0, 1'b0};
      m0 <= '{1'b0, 0, 1'b0, 1'b0};
    end else begin
      m8 <= step(m8, start, stop, hold, 8);
      m0 <= step(m0, start, stop, hold, 0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m8_state", int'(cs8), phase_of(m8));
    check("m8_busy", int'(busy8), int'(m8.active));
    check("m8_done", int'(done8), int'(m8.done));
    check("m8_aborted", int'(ab8), int'(m8.aborted));
    check("m0_state", int'(cs0), phase_of(m0));
    check("m0_done", int'(done0), 0);
    check("m0_aborted", int'(ab0), int'(m0.aborted));
    check("onehot8", int'($countones(cs8) <= 1), 1);
    check("onehot0", int'($countones(cs0) <= 1), 1);
    check("excl8", int'(done8 & ab8), 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_idle();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(2);
    check("rst_state", int'(cs8), 0);
    check("rst_busy", int'(busy8), 0);
    check("rst_done", int'(done8), 0);
    rst_n = 1'b1;
    tick(2);

    // Basic timing: READY t1..t4, SET t5..t8, GOING t9..t16, done at t17.
    pulse_start();
    check("s1_t1", int'(cs8), 1);
    tick(3); check("s1_t4", int'(cs8), 1);
    tick();  check("s1_t5", int'(cs8), 2);
    tick(3); check("s1_t8", int'(cs8), 2);
    tick();  check("s1_t9", int'(cs8), 4);
    tick(7); check("s1_t16", int'(cs8), 4);
    tick();  check("s1_t17_state", int'(cs8), 0);
    check("s1_t17_done", int'(done8), 1);
    check("s1_t17_busy", int'(busy8), 0);
    tick();  check("s1_t18_done", int'(done8), 0);

    // Stop in the second SET cycle.
    go_idle();
    pulse_start();
    tick(5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s2_state", int'(cs8), 0);
    check("s2_aborted", int'(ab8), 1);
    check("s2_done", int'(done8), 0);
    tick();
    check("s2_aborted_clr", int'(ab8), 0);

    // Hold for five cycles from the second READY cycle.
    go_idle();
    pulse_start();
    tick();
    hold = 1'b1;
    tick(5);
    hold = 1'b0;
    check("s3_t7", int'(cs8), 1);
    tick(2);  check("s3_t9", int'(cs8), 1);
    tick();   check("s3_t10", int'(cs8), 2);
    tick(11); check("s3_t21", int'(cs8), 4);
    tick();   check("s3_t22_done", int'(done8), 1);

    // Endless GOING on the zero-dwell instance.
    go_idle();
    pulse_start();
    tick(8);   check("s4_t9", int'(cs0), 4);
    tick(100); check("s4_t109", int'(cs0), 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s4_state", int'(cs0), 0);
    check("s4_aborted", int'(ab0), 1);

    // start+stop together in IDLE, then start while busy.
    go_idle();
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("s5_stay_idle", int'(cs8), 0);
    check("s5_no_abort", int'(ab8), 0);
    pulse_start();
    tick(11);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(4); check("s5_t17_done", int'(done8), 1);
    tick();  check("s5_t18_idle", int'(cs8), 0);

    // Asynchronous reset mid-GOING.
    go_idle();
    pulse_start();
    tick(11);
    #2 rst_n = 1'b0;
    #1;
    check("s6_state", int'(cs8), 0);
    check("s6_busy", int'(busy8), 0);
    check("s6_done", int'(done8), 0);
    check("s6_aborted", int'(ab8), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Continuous start: exactly one IDLE cycle between sequences.
    start = 1'b1;
    tick();
    tick(16); check("s7_t17_done", int'(done8), 1);
    check("s7_t17_idle", int'(cs8), 0);
    tick();   check("s7_t18_ready", int'(cs8), 1);
    tick(16); check("s7_t34_done", int'(done8), 1);
    tick();   check("s7_t35_ready", int'(cs8), 1);
    start = 1'b0;
    go_idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 19) == 0);
      hold  = ($urandom_range(0, 4) == 0);
      tick();
    end
    start = 1'b0;
    stop  = 1'b0;
    hold  = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_rsg_sequencer
